// File: rtl/mb_pkg.sv
// rtl/mb_pkg.sv - shared fixed-point type, FSM states and saturating add for the metaball renderer
package mb_pkg;

    typedef logic [31:0] fix_t;

    localparam fix_t FIX_ONE = 32'h0001_0000;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, SWAP} state_t;

    function automatic fix_t sat_add(input fix_t a, input fix_t b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

endpackage

// File: rtl/mb_frame_renderer_field_classify.sv
// rtl/mb_frame_renderer_field_classify.sv - saturating sum of ball fields and palette lookup by threshold count
module field_classify
    import mb_pkg::*;
#(
    parameter int N_BALLS = 2,
    parameter int N_LVL   = 1,
    parameter int PX_W    = 12
) (
    input  logic [32*N_BALLS-1:0]     vals_i,
    input  logic [32*N_LVL-1:0]       thresh_i,
    input  logic [PX_W*(N_LVL+1)-1:0] palette_i,
    output logic [PX_W-1:0]           color_o
);

    fix_t sum;
    int   level;

    // Thresholds need not be ascending for correctness: the level is a plain count.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_BALLS; i++) begin
            sum = sat_add(sum, vals_i[32*i +: 32]);
        end
        level = 0;
        for (int k = 0; k < N_LVL; k++) begin
            if (sum >= thresh_i[32*k +: 32]) begin
                level = level + 1;
            end
        end
        color_o = palette_i[PX_W*level +: PX_W];
    end

endmodule

// File: rtl/mb_frame_renderer.sv
// rtl/mb_frame_renderer.sv - pixel sequencer: strobes evaluators, classifies fields, writes split framebuffer, swaps
module mb_frame_renderer
    import mb_pkg::*;
#(
    parameter int   N_BALLS = 2,
    parameter int   COLS    = 32,
    parameter int   ROWS    = 32,
    parameter fix_t STEP    = FIX_ONE >> 1,
    parameter int   N_LVL   = 1,
    parameter int   PX_W    = 12,
    parameter int   AW      = $clog2(COLS*ROWS/2)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    output logic                       px_stb,
    output logic [31:0]                p_x,
    output logic [31:0]                p_y,
    input  logic [N_BALLS-1:0]         mb_vld,
    input  logic [32*N_BALLS-1:0]      mb_out,
    input  logic [32*N_LVL-1:0]        thresh,
    input  logic [PX_W*(N_LVL+1)-1:0]  palette,
    output logic                       w_en,
    output logic                       w_half,
    output logic [AW-1:0]              w_addr,
    output logic [PX_W-1:0]            w_data,
    output logic                       swap_req,
    input  logic                       swap_ack,
    output logic                       frame_done,
    output logic                       busy
);

    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int HALF = ROWS / 2;

    state_t                 state_q, state_d;
    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [N_BALLS-1:0]     collect_q, collect_d;
    logic [32*N_BALLS-1:0]  vals_q, vals_d;
    logic                   w_en_q, w_en_d;
    logic                   w_half_q, w_half_d;
    logic [AW-1:0]          w_addr_q, w_addr_d;
    logic [PX_W-1:0]        w_data_q, w_data_d;
    logic                   frame_done_q, frame_done_d;
    logic [N_BALLS-1:0]     seen;
    logic [PX_W-1:0]        color;

    field_classify #(
        .N_BALLS (N_BALLS),
        .N_LVL   (N_LVL),
        .PX_W    (PX_W)
    ) u_classify (
        .vals_i    (vals_q),
        .thresh_i  (thresh),
        .palette_i (palette),
        .color_o   (color)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        collect_d    = collect_q;
        vals_d       = vals_q;
        w_en_d       = 1'b0;
        w_half_d     = w_half_q;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        frame_done_d = 1'b0;
        seen         = collect_q | mb_vld;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = ISSUE;
            end
            ISSUE: begin
                collect_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                // A repeated pulse from the same ball simply refreshes its latched value.
                collect_d = seen;
                for (int i = 0; i < N_BALLS; i++) begin
                    if (mb_vld[i]) vals_d[32*i +: 32] = mb_out[32*i +: 32];
                end
                if (&seen) state_d = WRITE;
            end
            WRITE: begin
                w_en_d   = 1'b1;
                w_half_d = (int'(row_q) >= HALF);
                w_addr_d = AW'((int'(row_q) % HALF) * COLS + int'(col_q));
                w_data_d = color;
                state_d  = ISSUE;
                if (int'(col_q) == COLS - 1) begin
                    col_d = '0;
                    if (int'(row_q) == ROWS - 1) begin
                        row_d   = '0;
                        state_d = SWAP;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            SWAP: begin
                if (swap_ack) begin
                    frame_done_d = 1'b1;
                    col_d        = '0;
                    row_d        = '0;
                    state_d      = en ? ISSUE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            collect_q    <= '0;
            vals_q       <= '0;
            w_en_q       <= 1'b0;
            w_half_q     <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            collect_q    <= collect_d;
            vals_q       <= vals_d;
            w_en_q       <= w_en_d;
            w_half_q     <= w_half_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign px_stb     = (state_q == ISSUE);
    assign swap_req   = (state_q == SWAP);
    assign busy       = (state_q != IDLE);
    assign p_x        = fix_t'(col_q) * STEP;
    assign p_y        = fix_t'(row_q) * STEP;
    assign w_en       = w_en_q;
    assign w_half     = w_half_q;
    assign w_addr     = w_addr_q;
    assign w_data     = w_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mb_frame_renderer.sv
// tb/tb_mb_frame_renderer.sv - randomized bench with evaluator model and frame scoreboard for mb_frame_renderer
module tb_mb_frame_renderer;

    localparam int COLS = 4;
    localparam int ROWS = 4;
    localparam int NB   = 2;
    localparam int NL   = 2;
    localparam int PXW  = 12;
    localparam int AW   = 3;
    localparam int NPX  = COLS * ROWS;

    logic              clk;
    logic              rst;
    logic              en;
    logic              px_stb;
    logic [31:0]       p_x;
    logic [31:0]       p_y;
    logic [NB-1:0]     mb_vld;
    logic [32*NB-1:0]  mb_out;
    logic [32*NL-1:0]  thresh;
    logic [PXW*3-1:0]  palette;
    logic              w_en;
    logic              w_half;
    logic [AW-1:0]     w_addr;
    logic [PXW-1:0]    w_data;
    logic              swap_req;
    logic              swap_ack;
    logic              frame_done;
    logic              busy;

    mb_frame_renderer #(
        .N_BALLS (NB),
        .COLS    (COLS),
        .ROWS    (ROWS),
        .STEP    (32'h0000_8000),
        .N_LVL   (NL),
        .PX_W    (PXW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .px_stb     (px_stb),
        .p_x        (p_x),
        .p_y        (p_y),
        .mb_vld     (mb_vld),
        .mb_out     (mb_out),
        .thresh     (thresh),
        .palette    (palette),
        .w_en       (w_en),
        .w_half     (w_half),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .frame_done (frame_done),
        .busy       (busy)
    );

    typedef struct {
        logic        half;
        logic [2:0]  addr;
        logic [11:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [11:0] data;
        int          cyc;
        logic [31:0] px;
        logic [31:0] py;
    } px_t;

    wr_t         obs_q[$];
    px_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          off = 1000;
    int          l0 = 0, l1 = 0, r0 = 0;
    bit          rep = 0, junk = 0;
    logic [31:0] v0, v1, rv;
    int          mode = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 32'h3FFF));
            1:       return 32'h0000_4000;
            2:       return 32'h0000_8000;
            default: return $urandom;
        endcase
    endfunction

    // Reference: clamp the true sum, count thresholds met, pick the palette word.
    function automatic logic [11:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [11:0] pal [3];
        longint      s;
        int          lvl;
        pal[0] = 12'h000;
        pal[1] = 12'h00F;
        pal[2] = 12'hFFF;
        s = longint'(a) + longint'(b);
        if (s > 64'h0000_0000_FFFF_FFFF) s = 64'h0000_0000_FFFF_FFFF;
        lvl = 0;
        if (s >= 64'h8000)  lvl++;
        if (s >= 64'h10000) lvl++;
        return pal[lvl];
    endfunction

    always @(posedge clk) begin
        #1;
        cyc++;
        if (w_en) obs_q.push_back('{w_half, w_addr, w_data, cyc});
        if (px_stb) begin
            off  = 0;
            rep  = 0;
            junk = 0;
            r0   = 0;
            case (mode)
                0: begin v0 = 32'h4000; v1 = 32'h4000; l0 = 2; l1 = 2; end
                1: begin v0 = 32'hFFFF_0000; v1 = 32'h0002_0000; l0 = 2; l1 = 2; end
                2: begin
                    v0 = 32'h0001_0000; l0 = 1; rep = 1; r0 = 3; rv = 32'h4000;
                    v1 = 32'h4000; l1 = 5;
                end
                default: begin
                    v0   = rnd_val();
                    v1   = rnd_val();
                    l0   = int'($urandom_range(1, 6));
                    l1   = int'($urandom_range(1, 6));
                    junk = bit'($urandom_range(0, 1));
                    if (l0 < l1 && $urandom_range(0, 1) == 1) begin
                        rep = 1;
                        r0  = int'($urandom_range(l0 + 1, l1));
                        rv  = rnd_val();
                    end
                end
            endcase
            exp_q.push_back('{model(rep ? rv : v0, v1), cyc + ((l0 > l1) ? l0 : l1) + 2, p_x, p_y});
        end else if (off < 1000) begin
            off++;
        end
        mb_vld[0]     = (off == l0) || (rep && off == r0) || (junk && off == 0);
        mb_vld[1]     = (off == l1) || (junk && off == 0);
        mb_out[31:0]  = (off == l0) ? v0 : ((rep && off == r0) ? rv : $urandom);
        mb_out[63:32] = (off == l1) ? v1 : $urandom;
    end

    task automatic check_zero(input string pfx);
        chk({pfx, "_px_stb"}, px_stb, 0);
        chk({pfx, "_w_en"}, w_en, 0);
        chk({pfx, "_w_half"}, w_half, 0);
        chk({pfx, "_w_addr"}, w_addr, 0);
        chk({pfx, "_w_data"}, w_data, 0);
        chk({pfx, "_swap_req"}, swap_req, 0);
        chk({pfx, "_frame_done"}, frame_done, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_p_x"}, p_x, 0);
        chk({pfx, "_p_y"}, p_y, 0);
    endtask

    task automatic do_frame(input int ack_delay, input int next_mode, input bit drop_en, input bit en_after);
        int  t;
        int  hi;
        int  stbs;
        wr_t w;
        px_t e;
        t = 0;
        while (obs_q.size() < NPX && t < 2000) begin
            @(negedge clk);
            t++;
            if (drop_en && exp_q.size() >= 6) en = 1'b0;
        end
        chk("frame_writes_in_time", (t < 2000), 1);
        t = 0;
        while (!swap_req && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("swap_req_raised", swap_req, 1);
        chk("writes_per_frame", obs_q.size(), NPX);
        hi   = 0;
        stbs = 0;
        for (int i = 0; i < ack_delay; i++) begin
            hi   += int'(swap_req);
            stbs += int'(px_stb);
            @(negedge clk);
        end
        chk("swap_req_held", hi, ack_delay);
        chk("no_stb_in_swap", stbs, 0);
        mode     = next_mode;
        en       = en_after;
        swap_ack = 1'b1;
        @(negedge clk);
        chk("frame_done_pulse", frame_done, 1);
        chk("swap_req_dropped", swap_req, 0);
        swap_ack = 1'b0;
        @(negedge clk);
        chk("frame_done_single", frame_done, 0);
        for (int n = 0; n < NPX; n++) begin
            if (obs_q.size() == 0 || exp_q.size() == 0) break;
            w = obs_q.pop_front();
            e = exp_q.pop_front();
            chk($sformatf("px%0d_half", n), w.half, ((n / COLS) >= ROWS / 2));
            chk($sformatf("px%0d_addr", n), w.addr, ((n / COLS) % (ROWS / 2)) * COLS + n % COLS);
            chk($sformatf("px%0d_data", n), w.data, e.data);
            chk($sformatf("px%0d_time", n), w.cyc, e.cyc);
            chk($sformatf("px%0d_p_x", n), e.px, (n % COLS) * 32'h8000);
            chk($sformatf("px%0d_p_y", n), e.py, (n / COLS) * 32'h8000);
        end
    endtask

    initial begin
        int t;
        int n;
        rst      = 1'b1;
        en       = 1'b0;
        swap_ack = 1'b0;
        thresh   = {32'h0001_0000, 32'h0000_8000};
        palette  = {12'hFFF, 12'h00F, 12'h000};
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            n += int'(busy) + int'(px_stb);
        end
        chk("idle_without_en", n, 0);

        mode = 0;
        en   = 1'b1;
        do_frame(0, 1, 1'b0, 1'b1);
        do_frame(10, 2, 1'b0, 1'b1);
        do_frame(3, 3, 1'b0, 1'b1);
        do_frame(2, 3, 1'b1, 1'b0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            n += int'(busy) + int'(px_stb);
        end
        chk("idle_after_en_drop", n, 0);
        chk("no_issue_after_en_drop", exp_q.size(), 0);

        mode = 3;
        en   = 1'b1;
        t    = 0;
        while (exp_q.size() < 10 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("reached_pixel9", (exp_q.size() >= 10), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("midframe_rst");
        repeat (2) @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        rst = 1'b0;
        do_frame(int'($urandom_range(0, 5)), 3, 1'b0, 1'b0);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            n += int'(busy) + int'(px_stb);
        end
        chk("idle_at_end", n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
